// File: rtl/hazard_ctrl_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_unit_pkg : shared types for the pipeline hazard controller
// Rev 1.0
// ---------------------------------------------------------------------------
package hazard_ctrl_unit_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    PC_NEXT = 3'd0,
    PC_BEQ  = 3'd1,
    PC_BNE  = 3'd2,
    PC_J    = 3'd3,
    PC_JR   = 3'd4,
    PC_JAL  = 3'd5
  } pcsrc_t;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : event counter that sticks at all-ones instead of wrapping
// Rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_unit : freeze / redirect / load-use control for the 5-stage pipe
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int PCSRC_W       = 3,
  parameter int REG_W         = 5,
  parameter int RESOLVE_STAGE = 2,
  parameter int CNT_W         = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [PCSRC_W-1:0] PCsrc,
  input  logic               zero,
  input  logic               ihit,
  input  logic               dmem_req,
  input  logic               dhit,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               ex_memread,
  input  logic [REG_W-1:0]   ex_rd,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               flushed,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic c_flush_idex  = (RESOLVE_STAGE >= 2);
  localparam logic c_flush_exmem = (RESOLVE_STAGE == 3);

  hz_state_t r_state;
  logic      r_pend_redir;
  logic      r_flushed;
  logic      w_taken;
  logic      w_freeze;
  logic      w_loaduse;
  logic      w_redirect;

  always_comb begin
    w_taken = 1'b0;
    if (PCsrc == PCSRC_W'(PC_BEQ)) begin
      w_taken = zero;
    end else if (PCsrc == PCSRC_W'(PC_BNE)) begin
      w_taken = ~zero;
    end else if ((PCsrc == PCSRC_W'(PC_J)) || (PCsrc == PCSRC_W'(PC_JR)) ||
                 (PCsrc == PCSRC_W'(PC_JAL))) begin
      w_taken = 1'b1;
    end
  end

  assign w_freeze   = ~ihit | (dmem_req & ~dhit);
  assign w_loaduse  = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign w_redirect = (w_taken | r_pend_redir) & ~w_freeze;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (w_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (w_redirect) begin
      // squash only the stages younger than the one resolving the redirect
      ifid_flush  = 1'b1;
      idex_flush  = c_flush_idex;
      exmem_flush = c_flush_exmem;
    end else if (w_loaduse) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // a redirect seen while frozen is parked in HOLD until the pipe can move
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= HZ_RUN;
      r_pend_redir <= 1'b0;
      r_flushed    <= 1'b0;
    end else begin
      r_flushed <= w_redirect;
      case (r_state)
        HZ_RUN: begin
          if (w_freeze && w_taken) begin
            r_state      <= HZ_HOLD;
            r_pend_redir <= 1'b1;
          end
        end
        HZ_HOLD: begin
          if (!w_freeze) begin
            r_state      <= HZ_RUN;
            r_pend_redir <= 1'b0;
          end
        end
        default: begin
          r_state      <= HZ_RUN;
          r_pend_redir <= 1'b0;
        end
      endcase
    end
  end

  assign flushed = r_flushed;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (~pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_redirect),
    .count (flush_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit : directed checks of the hazard controller
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [2:0] PCsrc;
  logic       zero, ihit, dmem_req, dhit, ex_memread;
  logic [4:0] id_rs, id_rt, ex_rd;

  // resolve-in-EX instance, 16-bit counters
  logic        a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en;
  logic        a_ifid_fl, a_idex_fl, a_exmem_fl, a_flushed;
  logic [15:0] a_stall, a_flush;
  // resolve-in-MEM instance
  logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en;
  logic        b_ifid_fl, b_idex_fl, b_exmem_fl, b_flushed;
  logic [15:0] b_stall, b_flush;
  // 4-bit counter instance
  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_fl, s_idex_fl, s_exmem_fl, s_flushed;
  logic [3:0]  s_stall, s_flush;

  int errs   = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl_unit #(.RESOLVE_STAGE(2), .CNT_W(16)) dut_a (
    .CLK(CLK), .nRST(nRST), .PCsrc(PCsrc), .zero(zero), .ihit(ihit), .dmem_req(dmem_req),
    .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en), .exmem_en(a_exmem_en),
    .memwb_en(a_memwb_en), .ifid_flush(a_ifid_fl), .idex_flush(a_idex_fl),
    .exmem_flush(a_exmem_fl), .flushed(a_flushed), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  hazard_ctrl_unit #(.RESOLVE_STAGE(3), .CNT_W(16)) dut_b (
    .CLK(CLK), .nRST(nRST), .PCsrc(PCsrc), .zero(zero), .ihit(ihit), .dmem_req(dmem_req),
    .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en), .exmem_en(b_exmem_en),
    .memwb_en(b_memwb_en), .ifid_flush(b_ifid_fl), .idex_flush(b_idex_fl),
    .exmem_flush(b_exmem_fl), .flushed(b_flushed), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  hazard_ctrl_unit #(.RESOLVE_STAGE(2), .CNT_W(4)) dut_s (
    .CLK(CLK), .nRST(nRST), .PCsrc(PCsrc), .zero(zero), .ihit(ihit), .dmem_req(dmem_req),
    .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_fl), .idex_flush(s_idex_fl),
    .exmem_flush(s_exmem_fl), .flushed(s_flushed), .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    PCsrc = 3'd0; zero = 1'b0; ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; ex_memread = 1'b0; ex_rd = 5'd0;
  endtask

  task automatic reset_pulse();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    #1;
  endtask

  task automatic check_all_en(input string tag);
    check({tag, "_en"}, {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en}, 32'h1f);
    check({tag, "_fl"}, {a_ifid_fl, a_idex_fl, a_exmem_fl}, 32'h0);
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    tick();
    tick();
    // reset state
    check("rst_flushed", a_flushed, 0);
    check("rst_stall", a_stall, 0);
    check("rst_flush", a_flush, 0);
    check_all_en("rst");
    nRST = 1'b1;
    tick();

    // load-use on rs: one bubble
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
    #1;
    check("lu_pc_en", a_pc_en, 0);
    check("lu_ifid_en", a_ifid_en, 0);
    check("lu_idex_fl", a_idex_fl, 1);
    check("lu_exmem_en", {a_exmem_en, a_memwb_en}, 32'h3);
    tick();
    ex_memread = 1'b0;
    #1;
    check("lu_after_pc", a_pc_en, 1);
    check("lu_after_fl", a_idex_fl, 0);
    check("lu_stall", a_stall, 1);
    // r0 never creates a hazard
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    check("lu_r0_pc", a_pc_en, 1);
    // match on rt only
    ex_rd = 5'd9; id_rt = 5'd9; id_rs = 5'd2;
    #1;
    check("lu_rt_pc", a_pc_en, 0);
    idle();

    // taken beq
    reset_pulse();
    PCsrc = 3'd1; zero = 1'b1;
    #1;
    check("beq_fl_a", {a_ifid_fl, a_idex_fl, a_exmem_fl}, 32'h6);
    check("beq_fl_b", {b_ifid_fl, b_idex_fl, b_exmem_fl}, 32'h7);
    check("beq_pc_en", a_pc_en, 1);
    tick();
    PCsrc = 3'd0;
    #1;
    check("beq_flushed", a_flushed, 1);
    check("beq_flush_cnt", a_flush, 1);
    tick();
    check("beq_flushed_end", a_flushed, 0);
    // untaken beq, then taken/untaken bne
    PCsrc = 3'd1; zero = 1'b0;
    #1;
    check("beq_nt_fl", {a_ifid_fl, a_idex_fl, a_exmem_fl}, 32'h0);
    PCsrc = 3'd2; zero = 1'b1;
    #1;
    check("bne_nt_fl", a_ifid_fl, 0);
    PCsrc = 3'd6;
    #1;
    check("pcsrc6_fl", a_ifid_fl, 0);
    tick();
    check("nt_flush_cnt", a_flush, 1);
    idle();

    // redirect arriving during a data-memory freeze
    reset_pulse();
    PCsrc = 3'd3; dmem_req = 1'b1; dhit = 1'b0;
    #1;
    check("frz_fl", {a_ifid_fl, a_idex_fl, a_exmem_fl}, 32'h0);
    check("frz_en", {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en}, 32'h0);
    tick();
    PCsrc = 3'd0;
    repeat (3) tick();
    check("frz_stall", a_stall, 4);
    check("frz_flushed", a_flushed, 0);
    dhit = 1'b1;
    #1;
    check("frz_rel_fl", {a_ifid_fl, a_idex_fl}, 32'h3);
    check("frz_rel_pc", a_pc_en, 1);
    tick();
    dmem_req = 1'b0;
    #1;
    check("frz_flushed_pulse", a_flushed, 1);
    check("frz_flush_cnt", a_flush, 1);
    check("frz_back_run", a_ifid_fl, 0);
    tick();
    check("frz_pulse_end", a_flushed, 0);
    idle();

    // redirect and load-use together: redirect wins
    reset_pulse();
    PCsrc = 3'd5; ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd1; id_rt = 5'd8;
    #1;
    check("pri_pc_en", a_pc_en, 1);
    check("pri_ifid_en", a_ifid_en, 1);
    check("pri_fl_a", {a_ifid_fl, a_idex_fl, a_exmem_fl}, 32'h6);
    check("pri_fl_b", {b_ifid_fl, b_idex_fl, b_exmem_fl}, 32'h7);
    tick();
    check("pri_stall", a_stall, 0);
    idle();

    // counter saturation
    reset_pulse();
    ihit = 1'b0;
    repeat (20) tick();
    check("sat_stall_4b", s_stall, 15);
    check("sat_stall_16b", a_stall, 20);
    ihit = 1'b1;

    // reset while a redirect is parked discards it
    PCsrc = 3'd4; dmem_req = 1'b1; dhit = 1'b0;
    tick();
    PCsrc = 3'd0;
    nRST = 1'b0;
    #1;
    check("midrst_stall", a_stall, 0);
    check("midrst_flush", a_flush, 0);
    check("midrst_flushed", a_flushed, 0);
    nRST = 1'b1;
    idle();
    #1;
    check_all_en("midrst");
    tick();
    check("midrst_no_pulse", a_flushed, 0);
    check("midrst_no_cnt", a_flush, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
